// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_if
// Brief   : Serial line, consumer handshake and status bundle for uart_rx.
// Revision: 1.0
// ============================================================================
interface uart_rx_if;
    logic       rx;
    logic       data_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport slave (
        input  rx,
        input  data_ack,
        output data_out,
        output data_valid,
        output data_ready,
        output frame_err,
        output overrun,
        output busy
    );

    modport master (
        output rx,
        output data_ack,
        input  data_out,
        input  data_valid,
        input  data_ready,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : 8N1 UART receiver with mid-bit sampling, overrun and framing flags.
// Revision: 1.0
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    uart_rx_if.slave   bus
);
    localparam int              CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic             r_rx_meta;
    logic             r_rx_s;
    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_out;
    logic             r_valid;
    logic             r_ready;
    logic             r_ferr;
    logic             r_ovr;

    logic             w_busy;
    logic             w_cnt_clr;
    logic             w_sample_bit;
    logic             w_good;
    logic             w_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) w_next = S_START;
            end
            S_START: begin
                if (r_cnt == c_HALF) w_next = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if ((r_cnt == c_LAST) && (r_idx == 3'd7)) w_next = S_STOP;
            end
            S_STOP: begin
                if (r_cnt == c_LAST) w_next = r_rx_s ? S_IDLE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                // A held-low line (break) must return high before a new start.
                if (r_rx_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy       = (r_state != S_IDLE);
        w_cnt_clr    = 1'b0;
        w_sample_bit = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        case (r_state)
            S_IDLE:      w_cnt_clr = 1'b1;
            S_WAIT_IDLE: w_cnt_clr = 1'b1;
            S_START:     w_cnt_clr = (r_cnt == c_HALF);
            S_DATA: begin
                w_cnt_clr    = (r_cnt == c_LAST);
                w_sample_bit = (r_cnt == c_LAST);
            end
            S_STOP: begin
                w_cnt_clr = (r_cnt == c_LAST);
                w_good    = (r_cnt == c_LAST) &&  r_rx_s;
                w_bad     = (r_cnt == c_LAST) && !r_rx_s;
            end
            default: w_cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
            if (r_state == S_START) begin
                r_idx <= 3'd0;
            end else if (w_sample_bit) begin
                r_idx          <= r_idx + 3'd1;
                r_shift[r_idx] <= r_rx_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= 8'h00;
            r_valid    <= 1'b0;
            r_ready    <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_valid <= w_good;
            r_ferr  <= w_bad;
            if (w_good) begin
                r_data_out <= r_shift;
                r_ready    <= 1'b1;
                // A simultaneous acknowledge consumes the old byte, so no overrun.
                if (r_ready && bus.data_ack) r_ovr <= 1'b0;
                else if (r_ready)            r_ovr <= 1'b1;
            end else if (r_ready && bus.data_ack) begin
                r_ready <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_valid;
    assign bus.data_ready = r_ready;
    assign bus.frame_err  = r_ferr;
    assign bus.overrun    = r_ovr;
    assign bus.busy       = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Directed and randomized frames on uart_rx against a byte-level model.
// Revision: 1.0
// ============================================================================
module tb_uart_rx;
    localparam int C  = 16;
    localparam int C2 = 868;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    uart_rx_if bus();
    uart_rx_if bus2();

    uart_rx #(.CLKS_PER_BIT(C))  u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    uart_rx #(.CLKS_PER_BIT(C2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int         vcnt = 0;
    int         fcnt = 0;
    int         busy_cnt = 0;
    int         vcyc = 0;
    int         vcnt2 = 0;
    logic [7:0] q2[$];

    always @(posedge clk) begin
        #1;
        if (bus.data_valid === 1'b1) begin
            vcnt++;
            vcyc = cyc;
        end
        if (bus.frame_err === 1'b1) fcnt++;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus2.data_valid === 1'b1) begin
            vcnt2++;
            q2.push_back(bus2.data_out);
        end
    end

    // Byte-level model of the consumer-visible state.
    logic [7:0] m_data  = 8'h00;
    logic       m_ready = 1'b0;
    logic       m_ovr   = 1'b0;
    int         t_fall  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int cpb, input logic [7:0] b, input logic stopb, input logic which);
        logic v;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 1'b0 : (i == 9) ? stopb : b[i-1];
            if (which) bus2.rx = v;
            else       bus.rx  = v;
            if (i == 0) t_fall = cyc;
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic model_good(input logic [7:0] b);
        if (m_ready) m_ovr = 1'b1;
        m_ready = 1'b1;
        m_data  = b;
    endtask

    task automatic do_ack();
        bus.data_ack = 1'b1;
        @(negedge clk);
        bus.data_ack = 1'b0;
        @(negedge clk);
        if (m_ready) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_data"},  {24'd0, bus.data_out}, {24'd0, m_data});
        chk({tag, "_ready"}, {31'd0, bus.data_ready}, {31'd0, m_ready});
        chk({tag, "_ovr"},   {31'd0, bus.overrun}, {31'd0, m_ovr});
    endtask

    initial begin
        int v0, f0, b0, lat, exp_lat;
        logic [7:0] rb;
        logic       good;

        rst_n = 1'b0;
        bus.rx = 1'b1;  bus.data_ack = 1'b0;
        bus2.rx = 1'b1; bus2.data_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data",  {24'd0, bus.data_out}, 32'h0);
        chk("rst_valid", {31'd0, bus.data_valid}, 32'h0);
        chk("rst_ready", {31'd0, bus.data_ready}, 32'h0);
        chk("rst_ferr",  {31'd0, bus.frame_err}, 32'h0);
        chk("rst_ovr",   {31'd0, bus.overrun}, 32'h0);
        chk("rst_busy",  {31'd0, bus.busy}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single good frame and its latency.
        v0 = vcnt; f0 = fcnt;
        send(C, 8'h55, 1'b1, 1'b0);
        model_good(8'h55);
        repeat (3) @(negedge clk);
        chk("h55_vcnt", vcnt, v0 + 1);
        lat = vcyc - t_fall;
        exp_lat = 2 + (C - 1) / 2 + 9 * C + 2;
        chk("h55_latency", ((lat >= exp_lat - 1) && (lat <= exp_lat + 1)) ? 32'd1 : 32'd0, 32'd1);
        chk_model("h55");
        chk("h55_ferr", fcnt, f0);
        chk("h55_busy", {31'd0, bus.busy}, 32'h0);

        // Back-to-back frames without acknowledge produce overrun.
        do_ack();
        chk_model("ack1");
        v0 = vcnt;
        send(C, 8'hA3, 1'b1, 1'b0);
        model_good(8'hA3);
        send(C, 8'h0F, 1'b1, 1'b0);
        model_good(8'h0F);
        repeat (3) @(negedge clk);
        chk("b2b_vcnt", vcnt, v0 + 2);
        chk_model("b2b");
        do_ack();
        chk_model("ack2");

        // Short glitch is rejected.
        v0 = vcnt; b0 = busy_cnt;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_vcnt", vcnt, v0);
        chk("glitch_busy_len", ((busy_cnt - b0 > 0) && (busy_cnt - b0 < C)) ? 32'd1 : 32'd0, 32'd1);
        chk("glitch_idle", {31'd0, bus.busy}, 32'h0);

        // Bad stop bit followed by a held-low line.
        v0 = vcnt; f0 = fcnt;
        send(C, 8'hFF, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("ferr_cnt", fcnt, f0 + 1);
        chk("ferr_vcnt", vcnt, v0);
        chk("ferr_busy_low", {31'd0, bus.busy}, 32'h1);
        chk_model("ferr");
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("ferr_busy_rel", {31'd0, bus.busy}, 32'h0);

        // Reset during data bit 4 of 8'hC3.
        v0 = vcnt;
        bus.rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = rb_bit(8'hC3, i);
            repeat (C) @(negedge clk);
        end
        bus.rx = rb_bit(8'hC3, 4);
        repeat (C / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0;
        chk_model("midrst");
        chk("midrst_busy",  {31'd0, bus.busy}, 32'h0);
        chk("midrst_valid", {31'd0, bus.data_valid}, 32'h0);
        bus.rx = 1'b1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_vcnt", vcnt, v0);
        chk("midrst_idle", {31'd0, bus.busy}, 32'h0);
        send(C, 8'h3C, 1'b1, 1'b0);
        model_good(8'h3C);
        repeat (3) @(negedge clk);
        chk("after_rst_vcnt", vcnt, v0 + 1);
        chk_model("after_rst");

        // Randomized frames with random acknowledges and stop bits.
        for (int k = 0; k < 8; k++) begin
            rb   = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) do_ack();
            v0 = vcnt; f0 = fcnt;
            send(C, rb, good, 1'b0);
            if (good) begin
                model_good(rb);
            end else begin
                repeat ($urandom_range(0, 10)) @(negedge clk);
            end
            bus.rx = 1'b1;
            repeat (4) @(negedge clk);
            chk("rnd_vcnt", vcnt, v0 + (good ? 1 : 0));
            chk("rnd_fcnt", fcnt, f0 + (good ? 0 : 1));
            chk_model("rnd");
        end

        // Full-rate divisor: two frames at 115200 baud on a 100 MHz clock.
        v0 = vcnt2;
        send(C2, 8'h55, 1'b1, 1'b1);
        send(C2, 8'hA3, 1'b1, 1'b1);
        bus2.rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("baud_vcnt", vcnt2, v0 + 2);
        chk("baud_b0", {24'd0, (q2.size() > 0) ? q2[0] : 8'hxx}, 32'h55);
        chk("baud_b1", {24'd0, (q2.size() > 1) ? q2[1] : 8'hxx}, 32'hA3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic rb_bit(input logic [7:0] b, input int i);
        return b[i];
    endfunction
endmodule
`default_nettype wire
